// File: rtl/fire6_expand1_ofm_writer_if.sv
// Bus between the fire6_expand1 output stage and the ofm writer.
// It carries the sample pulse and ofm bank in one direction, and the RAM write port plus status in the other.
interface fire6_expand1_ofm_writer_if #(
    parameter int WIDTH    = 16,
    parameter int DSP_NO   = 256,
    parameter int WR_LANES = 8,
    parameter int AW       = 13
);
    logic                      start;
    logic                      fire6_expand1_sample;
    logic [WIDTH-1:0]          ofm [0:DSP_NO-1];
    logic                      wr_en;
    logic [AW-1:0]             wr_addr;
    logic [WR_LANES*WIDTH-1:0] wr_data;
    logic                      ram_feedback;
    logic                      busy;
    logic                      overrun;

    modport master (
        output start, fire6_expand1_sample, ofm,
        input  wr_en, wr_addr, wr_data, ram_feedback, busy, overrun
    );

    modport slave (
        input  start, fire6_expand1_sample, ofm,
        output wr_en, wr_addr, wr_data, ram_feedback, busy, overrun
    );
endinterface

// File: rtl/fire6_expand1_ofm_writer.sv
// Captures each fire6_expand1 ofm bank into a shadow and drains it to the ofm RAM, WR_LANES words per beat.
// It pulses ram_feedback once the last pixel of the layer is committed.
module fire6_expand1_ofm_writer #(
    parameter int WIDTH    = 16,
    parameter int DSP_NO   = 256,
    parameter int WR_LANES = 8,
    parameter int WOUT     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    fire6_expand1_ofm_writer_if.slave   bus
);
    localparam int NBEATS = DSP_NO / WR_LANES;
    localparam int PIXELS = WOUT * WOUT;
    localparam int AW     = $clog2(PIXELS * NBEATS);
    localparam int BW     = $clog2(NBEATS);
    localparam int PW     = $clog2(PIXELS);
    localparam int IW     = $clog2(DSP_NO);
    localparam int DW     = WR_LANES * WIDTH;

    localparam logic [BW-1:0] LAST_BEAT  = BW'(NBEATS - 1);
    localparam logic [PW-1:0] LAST_PIXEL = PW'(PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [BW-1:0]     beat_r, beat_s;
    logic [PW-1:0]     pixel_r, pixel_s;
    logic [WIDTH-1:0]  shadow_r [0:DSP_NO-1];
    logic              load_s;
    logic              wr_en_r, wr_en_s;
    logic [AW-1:0]     wr_addr_r, wr_addr_s;
    logic [DW-1:0]     wr_data_r, wr_data_s;
    logic              fb_r, fb_s;
    logic              busy_r;
    logic              overrun_r, overrun_s;

    // Channel-group major layout: all pixels of group b precede group b+1.
    function automatic logic [AW-1:0] beat_addr(input logic [BW-1:0] b, input logic [PW-1:0] p);
        return AW'(b) * AW'(PIXELS) + AW'(p);
    endfunction

    function automatic logic [DW-1:0] beat_lanes(input logic [WIDTH-1:0] src [0:DSP_NO-1],
                                                 input logic [BW-1:0]    b);
        logic [DW-1:0] r;
        logic [IW-1:0] idx;
        r = {DW{1'b0}};
        for (int l = 0; l < WR_LANES; l++) begin
            idx = IW'(int'(b) * WR_LANES + l);
            r[l*WIDTH +: WIDTH] = src[idx];
        end
        return r;
    endfunction

    // Next-state and next-output logic; beat_r is the beat currently shown on the write port.
    always_comb begin
        state_s   = state_r;
        beat_s    = beat_r;
        pixel_s   = pixel_r;
        load_s    = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        fb_s      = 1'b0;
        overrun_s = overrun_r;
        case (state_r)
            IDLE: begin
                if (bus.fire6_expand1_sample) begin
                    load_s    = 1'b1;
                    wr_en_s   = 1'b1;
                    beat_s    = {BW{1'b0}};
                    wr_addr_s = beat_addr({BW{1'b0}}, pixel_r);
                    wr_data_s = beat_lanes(bus.ofm, {BW{1'b0}});
                    state_s   = DRAIN;
                end else begin
                    state_s   = IDLE;
                end
            end
            DRAIN: begin
                if (beat_r != LAST_BEAT) begin
                    wr_en_s   = 1'b1;
                    beat_s    = beat_r + BW'(1);
                    wr_addr_s = beat_addr(beat_s, pixel_r);
                    wr_data_s = beat_lanes(shadow_r, beat_s);
                    if (bus.fire6_expand1_sample) begin
                        overrun_s = 1'b1;
                    end else begin
                        overrun_s = overrun_r;
                    end
                end else if (pixel_r == LAST_PIXEL) begin
                    // Layer complete: a coincident sample is ignored, not an overrun.
                    pixel_s = {PW{1'b0}};
                    fb_s    = 1'b1;
                    state_s = DONE;
                end else if (bus.fire6_expand1_sample) begin
                    pixel_s   = pixel_r + PW'(1);
                    load_s    = 1'b1;
                    wr_en_s   = 1'b1;
                    beat_s    = {BW{1'b0}};
                    wr_addr_s = beat_addr({BW{1'b0}}, pixel_s);
                    wr_data_s = beat_lanes(bus.ofm, {BW{1'b0}});
                    state_s   = DRAIN;
                end else begin
                    pixel_s = pixel_r + PW'(1);
                    state_s = IDLE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    pixel_s = {PW{1'b0}};
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state and registered write-port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            beat_r    <= {BW{1'b0}};
            pixel_r   <= {PW{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {AW{1'b0}};
            wr_data_r <= {DW{1'b0}};
            fb_r      <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            beat_r    <= beat_s;
            pixel_r   <= pixel_s;
            wr_en_r   <= wr_en_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
            fb_r      <= fb_s;
            busy_r    <= (state_s == DRAIN);
            overrun_r <= overrun_s;
        end
    end

    // Shadow bank: loads ofm only on an accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DSP_NO; i++) begin
                shadow_r[i] <= {WIDTH{1'b0}};
            end
        end else if (load_s) begin
            for (int i = 0; i < DSP_NO; i++) begin
                shadow_r[i] <= bus.ofm[i];
            end
        end
    end

    assign bus.wr_en        = wr_en_r;
    assign bus.wr_addr      = wr_addr_r;
    assign bus.wr_data      = wr_data_r;
    assign bus.ram_feedback = fb_r;
    assign bus.busy         = busy_r;
    assign bus.overrun      = overrun_r;

endmodule
